servo_pulse_decoder: RTL and testbench
======================================

// Module: servo_pulse_decoder
// PURPOSE
//  Receive-side counterpart of the servo PWM generator.
//  - Samples an external servo/RC pulse line and measures high time and rising-edge-to-rising-edge period in clk cycles.
//  - Publishes each completed measurement with a one-cycle strobe.
//  - Sits behind the Wishbone PWM peripheral as an input-capture channel (loopback test of the generator, or RC receiver input).
// PARAMETERS
//  CNT_W       32         width of width/period counters and outputs
//  FILT        4          glitch filter depth: level accepted after FILT equal consecutive samples
//  MIN_HIGH    50000      smallest in-range high time (1.0 ms @ 50 MHz)
//  MAX_HIGH    52778      largest in-range high time
//  PERIOD_MAX  1500000    counter value that declares loss of signal (30 ms @ 50 MHz)
// PORTS
//  clk        in   1      system clock
//  rst        in   1      reset, synchronous, active-high
//  en         in   1      capture enable
//  pwm_in     in   1      asynchronous servo pulse input
//  width      out  CNT_W  last measured high time, clk cycles
//  period     out  CNT_W  last measured rising-to-rising period, clk cycles
//  valid      out  1      1-cycle strobe: width/period/in_range updated this cycle
//  in_range   out  1      MIN_HIGH <= width <= MAX_HIGH for the published sample
//  timeout    out  1      level: signal lost; cleared on next valid
// BEHAVIOUR
//  Reset values: width=0, period=0, valid=0, in_range=0, timeout=0, state=IDLE, counters=0.
//  Input path:
//  - 2-flop synchronizer, then FILT-deep stability filter giving filtered level f.
//  - f changes only after FILT identical synchronized samples; filter resets to 0.
//  - rise/fall = 1-cycle pulses on f transitions.
//  - Constant input latency 2+FILT cycles on both edges, so widths are exact.
//  FSM:
//  - IDLE: counters held at 0. rise -> HIGH, hcnt=1, pcnt=1. First edge is never published.
//  - HIGH: hcnt++, pcnt++ each cycle; fall -> LOW (hcnt frozen).
//  - LOW: pcnt++; rise -> publish, then HIGH with hcnt=1, pcnt=1.
//  Publish (registered; valid high the cycle after rise is seen):
//  - width<=hcnt, period<=pcnt, in_range<=range check on hcnt, timeout<=0.
//  - Between publishes, width/period/in_range hold; valid is 0.
//  Timeout:
//  - In HIGH or LOW, pcnt==PERIOD_MAX with no rise that cycle -> timeout<=1, state IDLE, counters 0.
//  - Stuck-high and stuck-low are both caught. width/period keep the last good values.
//  Simultaneous rise and pcnt==PERIOD_MAX: rise wins -> normal publish, no timeout.
//  Counters saturate at all-ones; they never wrap (unreachable when PERIOD_MAX < 2^CNT_W-1).
//  en=0: state IDLE, counters 0, valid 0; outputs hold; filter keeps running.
//  - On re-enable, the first rise only starts a measurement.
//  rst mid-measurement: all outputs and state return to reset values next cycle; partial measurement discarded.
//  Spec-level period: generator frame = 1000001 cycles; AL=50000, AC=51389, AR=52778.
// STRUCTURE
//  Shared package servo_pkg:
//  - AL/AC/AR pulse constants, FRAME=1000000, default MIN_HIGH/MAX_HIGH/PERIOD_MAX.
//  - FSM state encoding (IDLE/HIGH/LOW), 2 bits.
//  - Used by both generator and decoder.
//  Sub-module pwm_in_filter (FILT): synchronizer + stability filter + rise/fall detect.
//  Top holds FSM, counters, output registers.
// TESTING
//  1. 51389 high / 1000001 period, 3 frames -> valid x2, width=51389, period=1000001, in_range=1, timeout=0.
//  2. 3-cycle high glitch (FILT=4) during LOW, and 3-cycle low glitch in HIGH -> no edge, next sample still width=51389.
//  3. Line held low after one frame -> timeout=1 exactly PERIOD_MAX cycles after last rise; two frames later valid, timeout=0.
//  4. 40000 and 60000 cycle highs -> valid with width=40000 / 60000, in_range=0 both.
//  5. rst pulse mid-HIGH -> outputs 0 next cycle; next rise gives no valid; following rise publishes correct values.
//  6. Rise arriving exactly at pcnt==PERIOD_MAX -> valid=1, period=PERIOD_MAX, timeout=0.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM generator and the servo pulse decoder:
// nominal pulse timing at 50 MHz, default decoder limits and the decoder FSM
// state encoding.
package servo_pkg;

  // Nominal servo pulse high times in clk cycles (left / centre / right).
  localparam int unsigned AL = 32'd50000;
  localparam int unsigned AC = 32'd51389;
  localparam int unsigned AR = 32'd52778;

  // Generator frame length; the measured rising-to-rising period is FRAME+1.
  localparam int unsigned FRAME = 32'd1000000;

  // Decoder defaults: in-range window is the full left..right swing, and
  // 30 ms without a rising edge means the signal is gone.
  localparam int unsigned MIN_HIGH_DEF   = AL;
  localparam int unsigned MAX_HIGH_DEF   = AR;
  localparam int unsigned PERIOD_MAX_DEF = 32'd1500000;

  // Decoder measurement FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } servo_state_e;

endpackage

// File: rtl/pwm_in_filter.sv
// Input conditioning for the servo pulse line: two-flop synchronizer, a
// FILT-deep stability filter and single-cycle rise/fall pulses on the
// filtered level. Both edges see the same latency, so measured widths are
// exact.
module pwm_in_filter #(
  parameter int unsigned FILT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in_i,
  output logic rise_o,
  output logic fall_o
);

  // Counter must hold 0..FILT-1; keep at least one bit for FILT=1.
  localparam int unsigned CW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          rise_q;
  logic          rise_d;
  logic          fall_q;
  logic          fall_d;

  // Two-flop synchronizer for the asynchronous pulse input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in_i;
      sync2_q <= sync1_q;
    end
  end

  // Flip the filtered level on the FILT-th consecutive differing sample.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = CNT_ZERO;
      rise_d  = sync2_q;
      fall_d  = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Filter state and registered edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Servo pulse decoder: measures high time and rising-to-rising period of a
// servo/RC pulse line in clk cycles, publishes each completed measurement
// with a one-cycle strobe and flags loss of signal.
module servo_pulse_decoder
  import servo_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned FILT       = 4,
  parameter int unsigned MIN_HIGH   = MIN_HIGH_DEF,
  parameter int unsigned MAX_HIGH   = MAX_HIGH_DEF,
  parameter int unsigned PERIOD_MAX = PERIOD_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             pwm_in_i,
  output logic [CNT_W-1:0] width_o,
  output logic [CNT_W-1:0] period_o,
  output logic             valid_o,
  output logic             in_range_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] PMAX_C = CNT_W'(PERIOD_MAX);

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + ONE;
    end
  endfunction

  logic rise;
  logic fall;
  logic pmax_hit;

  servo_state_e     state_q;
  servo_state_e     state_d;
  logic [CNT_W-1:0] hcnt_q;
  logic [CNT_W-1:0] hcnt_d;
  logic [CNT_W-1:0] pcnt_q;
  logic [CNT_W-1:0] pcnt_d;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] width_d;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] period_d;
  logic             valid_q;
  logic             valid_d;
  logic             in_range_q;
  logic             in_range_d;
  logic             timeout_q;
  logic             timeout_d;

  pwm_in_filter #(
    .FILT(FILT)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .pwm_in_i(pwm_in_i),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  // A rise landing on the limit cycle is a legal edge and wins over timeout.
  assign pmax_hit = (pcnt_q == PMAX_C) && !rise;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: disable parks in IDLE, timeout drops back to IDLE.
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_HIGH;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HIGH: begin
          if (pmax_hit) begin
            state_d = ST_IDLE;
          end else if (fall) begin
            state_d = ST_LOW;
          end else begin
            state_d = ST_HIGH;
          end
        end
        ST_LOW: begin
          if (rise) begin
            state_d = ST_HIGH;
          end else if (pmax_hit) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOW;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM outputs: counter updates, publish on rise in LOW, timeout flag.
  always_comb begin
    hcnt_d     = hcnt_q;
    pcnt_d     = pcnt_q;
    width_d    = width_q;
    period_d   = period_q;
    in_range_d = in_range_q;
    timeout_d  = timeout_q;
    valid_d    = 1'b0;
    if (!en_i) begin
      hcnt_d = ZERO;
      pcnt_d = ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // First edge after idle only starts a measurement.
          if (rise) begin
            hcnt_d = ONE;
            pcnt_d = ONE;
          end else begin
            hcnt_d = ZERO;
            pcnt_d = ZERO;
          end
        end
        ST_HIGH: begin
          if (pmax_hit) begin
            hcnt_d    = ZERO;
            pcnt_d    = ZERO;
            timeout_d = 1'b1;
          end else begin
            pcnt_d = sat_inc(pcnt_q);
            if (fall) begin
              hcnt_d = hcnt_q;
            end else begin
              hcnt_d = sat_inc(hcnt_q);
            end
          end
        end
        ST_LOW: begin
          if (rise) begin
            width_d    = hcnt_q;
            period_d   = pcnt_q;
            in_range_d = (hcnt_q >= MIN_C) && (hcnt_q <= MAX_C);
            timeout_d  = 1'b0;
            valid_d    = 1'b1;
            hcnt_d     = ONE;
            pcnt_d     = ONE;
          end else if (pmax_hit) begin
            hcnt_d    = ZERO;
            pcnt_d    = ZERO;
            timeout_d = 1'b1;
          end else begin
            pcnt_d = sat_inc(pcnt_q);
          end
        end
        default: begin
          hcnt_d = ZERO;
          pcnt_d = ZERO;
        end
      endcase
    end
  end

  // Counters and published result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q     <= ZERO;
      pcnt_q     <= ZERO;
      width_q    <= ZERO;
      period_q   <= ZERO;
      valid_q    <= 1'b0;
      in_range_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      hcnt_q     <= hcnt_d;
      pcnt_q     <= pcnt_d;
      width_q    <= width_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      in_range_q <= in_range_d;
      timeout_q  <= timeout_d;
    end
  end

  assign width_o    = width_q;
  assign period_o   = period_q;
  assign valid_o    = valid_q;
  assign in_range_o = in_range_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Self-checking bench for servo_pulse_decoder, run with time-scaled limits.
// Pulse trains are described as (high, period) frames; the reference model
// derives expected publishes and timeouts from the frame list alone.
module tb_servo_pulse_decoder;

  localparam int CNT_W = 32;
  localparam int FILT  = 4;
  localparam int MIN_H = 50;
  localparam int MAX_H = 53;
  localparam int PMAX  = 1500;
  localparam int FRM   = 1001;
  localparam int MID   = 51;

  logic             clk;
  logic             rst;
  logic             en;
  logic             pwm;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             in_range;
  logic             timeout;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  int   mon_w[$];
  int   mon_p[$];
  int   mon_c[$];
  logic mon_r[$];
  logic mon_t[$];
  int   to_c[$];
  logic prev_to = 1'b0;

  int   fr_h[$];
  int   fr_p[$];
  int   exp_w[$];
  int   exp_p[$];
  logic exp_r[$];
  int   exp_to;

  servo_pulse_decoder #(
    .CNT_W     (CNT_W),
    .FILT      (FILT),
    .MIN_HIGH  (MIN_H),
    .MAX_HIGH  (MAX_H),
    .PERIOD_MAX(PMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en),
    .pwm_in_i  (pwm),
    .width_o   (width),
    .period_o  (period),
    .valid_o   (valid),
    .in_range_o(in_range),
    .timeout_o (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe and every rising edge of the timeout flag.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      mon_w.push_back(int'(width));
      mon_p.push_back(int'(period));
      mon_r.push_back(in_range);
      mon_t.push_back(timeout);
      mon_c.push_back(cyc);
    end
    if (timeout === 1'b1 && prev_to !== 1'b1) to_c.push_back(cyc);
    prev_to <= timeout;
  end

  task automatic hold(input logic v, input int n);
    pwm = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_w.delete(); mon_p.delete(); mon_r.delete();
    mon_t.delete(); mon_c.delete(); to_c.delete();
  endtask

  task automatic do_reset();
    pwm = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_mon();
  endtask

  // One frame: rise, high h cycles, low for the rest of p. Glitched frames
  // carry a 3-cycle low dip inside the high and a 3-cycle spike in the low.
  task automatic drive_frame(input int h, input int p, input bit glitch);
    if (glitch) begin
      hold(1'b1, 20); hold(1'b0, 3); hold(1'b1, h - 23);
      hold(1'b0, 400); hold(1'b1, 3); hold(1'b0, p - h - 403);
    end else begin
      hold(1'b1, h);
      hold(1'b0, p - h);
    end
  endtask

  // Drive the frame table; the optional tail rise closes the last frame.
  task automatic run_frames(input bit glitch, input bit tail);
    for (int i = 0; i < fr_h.size(); i++) drive_frame(fr_h[i], fr_p[i], glitch);
    if (tail) begin
      hold(1'b1, 20);
      hold(1'b0, 40);
    end
  endtask

  // Each rise closes the frame before it: a gap beyond PMAX is a loss of
  // signal (no publish), otherwise that frame's high/period is published.
  function automatic void model_expect(input bit tail);
    exp_w.delete(); exp_p.delete(); exp_r.delete();
    exp_to = 0;
    for (int i = 0; i < fr_h.size(); i++) begin
      if (fr_p[i] > PMAX) begin
        exp_to++;
      end else if (i + 1 < fr_h.size() || tail) begin
        exp_w.push_back(fr_h[i]);
        exp_p.push_back(fr_p[i]);
        exp_r.push_back((fr_h[i] >= MIN_H) && (fr_h[i] <= MAX_H));
      end
    end
  endfunction

  task automatic test_reset();
    en = 1'b1; pwm = 1'b0; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (width !== 32'd0) begin miscompares++; $display("FAIL reset_width: got %0d want 0", width); end
    vectors++; if (period !== 32'd0) begin miscompares++; $display("FAIL reset_period: got %0d want 0", period); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid); end
    vectors++; if (in_range !== 1'b0) begin miscompares++; $display("FAIL reset_in_range: got %b want 0", in_range); end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    do_reset();
    fr_h = '{MID, MID, MID}; fr_p = '{FRM, FRM, FRM};
    run_frames(1'b0, 1'b0);
    model_expect(1'b0);
    vectors++;
    if (mon_w.size() !== exp_w.size()) begin miscompares++; $display("FAIL nominal_count: got %0d strobes want %0d", mon_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < mon_w.size(); i++) begin
      vectors++;
      if (mon_w[i] !== exp_w[i] || mon_p[i] !== exp_p[i] || mon_r[i] !== exp_r[i] || mon_t[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL nominal_sample%0d: got w=%0d p=%0d r=%b t=%b want w=%0d p=%0d r=%b t=0", i, mon_w[i], mon_p[i], mon_r[i], mon_t[i], exp_w[i], exp_p[i], exp_r[i]);
      end
    end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL nominal_timeout: got %b want 0", timeout); end
  endtask

  task automatic test_glitch();
    do_reset();
    fr_h = '{MID, MID, MID}; fr_p = '{FRM, FRM, FRM};
    run_frames(1'b1, 1'b1);
    model_expect(1'b1);
    vectors++;
    if (mon_w.size() !== exp_w.size()) begin miscompares++; $display("FAIL glitch_count: got %0d strobes want %0d", mon_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < mon_w.size(); i++) begin
      vectors++;
      if (mon_w[i] !== exp_w[i] || mon_p[i] !== exp_p[i] || mon_r[i] !== exp_r[i] || mon_t[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch_sample%0d: got w=%0d p=%0d r=%b t=%b want w=%0d p=%0d r=%b t=0", i, mon_w[i], mon_p[i], mon_r[i], mon_t[i], exp_w[i], exp_p[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    drive_frame(MID, FRM, 1'b0);
    hold(1'b1, MID);
    hold(1'b0, FRM - MID + PMAX);
    vectors++;
    if (mon_w.size() !== 1) begin miscompares++; $display("FAIL timeout_prior_strobes: got %0d want 1", mon_w.size()); end
    vectors++;
    if (to_c.size() !== 1) begin
      miscompares++; $display("FAIL timeout_events: got %0d want 1", to_c.size());
    end else if (mon_c.size() > 0) begin
      vectors++;
      if (to_c[0] - mon_c[mon_c.size() - 1] !== PMAX) begin
        miscompares++; $display("FAIL timeout_delay: got %0d cycles want %0d", to_c[0] - mon_c[mon_c.size() - 1], PMAX);
      end
    end
    vectors++; if (width !== 32'(MID) || period !== 32'(FRM)) begin miscompares++; $display("FAIL timeout_hold: got w=%0d p=%0d want w=%0d p=%0d", width, period, MID, FRM); end
    clear_mon();
    drive_frame(MID, FRM, 1'b0);
    vectors++; if (mon_w.size() !== 0) begin miscompares++; $display("FAIL timeout_first_rise: got %0d strobes want 0", mon_w.size()); end
    vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL timeout_level: got %b want 1", timeout); end
    hold(1'b1, MID);
    hold(1'b0, 40);
    vectors++;
    if (mon_w.size() !== 1) begin
      miscompares++; $display("FAIL timeout_recover_count: got %0d want 1", mon_w.size());
    end else begin
      vectors++;
      if (mon_w[0] !== MID || mon_p[0] !== FRM || mon_t[0] !== 1'b0) begin
        miscompares++; $display("FAIL timeout_recover: got w=%0d p=%0d t=%b want w=%0d p=%0d t=0", mon_w[0], mon_p[0], mon_t[0], MID, FRM);
      end
    end
  endtask

  task automatic test_range();
    do_reset();
    fr_h = '{40, 60, 49, 50, 53, 54}; fr_p = '{FRM, FRM, FRM, FRM, FRM, FRM};
    run_frames(1'b0, 1'b1);
    model_expect(1'b1);
    vectors++;
    if (mon_w.size() !== exp_w.size()) begin miscompares++; $display("FAIL range_count: got %0d strobes want %0d", mon_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < mon_w.size(); i++) begin
      vectors++;
      if (mon_w[i] !== exp_w[i] || mon_p[i] !== exp_p[i] || mon_r[i] !== exp_r[i] || mon_t[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL range_sample%0d: got w=%0d p=%0d r=%b t=%b want w=%0d p=%0d r=%b t=0", i, mon_w[i], mon_p[i], mon_r[i], mon_t[i], exp_w[i], exp_p[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    drive_frame(MID, FRM, 1'b0);
    hold(1'b1, 20);
    vectors++; if (width !== 32'(MID)) begin miscompares++; $display("FAIL rstmid_pre_width: got %0d want %0d", width, MID); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++; if (width !== 32'd0 || period !== 32'd0) begin miscompares++; $display("FAIL rstmid_counts: got w=%0d p=%0d want 0 0", width, period); end
    vectors++; if (valid !== 1'b0 || in_range !== 1'b0 || timeout !== 1'b0) begin miscompares++; $display("FAIL rstmid_flags: got v=%b r=%b t=%b want 0 0 0", valid, in_range, timeout); end
    clear_mon();
    // Line is still high: the filter re-acquires it as a fresh rise.
    hold(1'b1, 30);
    hold(1'b0, 950);
    vectors++; if (mon_w.size() !== 0) begin miscompares++; $display("FAIL rstmid_no_valid: got %0d strobes want 0", mon_w.size()); end
    fr_h = '{30, MID}; fr_p = '{980, FRM};
    for (int i = 1; i < fr_h.size(); i++) drive_frame(fr_h[i], fr_p[i], 1'b0);
    hold(1'b1, 20);
    hold(1'b0, 40);
    model_expect(1'b1);
    vectors++;
    if (mon_w.size() !== exp_w.size()) begin miscompares++; $display("FAIL rstmid_count: got %0d strobes want %0d", mon_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < mon_w.size(); i++) begin
      vectors++;
      if (mon_w[i] !== exp_w[i] || mon_p[i] !== exp_p[i] || mon_r[i] !== exp_r[i] || mon_t[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_sample%0d: got w=%0d p=%0d r=%b t=%b want w=%0d p=%0d r=%b t=0", i, mon_w[i], mon_p[i], mon_r[i], mon_t[i], exp_w[i], exp_p[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_boundary();
    do_reset();
    fr_h = '{MID, MID, MID, MID}; fr_p = '{FRM, PMAX, PMAX + 1, FRM};
    run_frames(1'b0, 1'b1);
    model_expect(1'b1);
    vectors++;
    if (mon_w.size() !== exp_w.size()) begin miscompares++; $display("FAIL boundary_count: got %0d strobes want %0d", mon_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < mon_w.size(); i++) begin
      vectors++;
      if (mon_w[i] !== exp_w[i] || mon_p[i] !== exp_p[i] || mon_r[i] !== exp_r[i] || mon_t[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL boundary_sample%0d: got w=%0d p=%0d r=%b t=%b want w=%0d p=%0d r=%b t=0", i, mon_w[i], mon_p[i], mon_r[i], mon_t[i], exp_w[i], exp_p[i], exp_r[i]);
      end
    end
    vectors++; if (to_c.size() !== exp_to) begin miscompares++; $display("FAIL boundary_timeouts: got %0d want %0d", to_c.size(), exp_to); end
  endtask

  task automatic test_enable();
    do_reset();
    fr_h = '{45, 45}; fr_p = '{FRM, FRM};
    run_frames(1'b0, 1'b0);
    vectors++; if (width !== 32'd45) begin miscompares++; $display("FAIL enable_pre_width: got %0d want 45", width); end
    en = 1'b0;
    clear_mon();
    fr_h = '{MID, MID}; fr_p = '{FRM, FRM};
    run_frames(1'b0, 1'b1);
    vectors++; if (mon_w.size() !== 0) begin miscompares++; $display("FAIL enable_off_strobes: got %0d want 0", mon_w.size()); end
    vectors++; if (width !== 32'd45 || period !== 32'(FRM) || timeout !== 1'b0) begin miscompares++; $display("FAIL enable_off_hold: got w=%0d p=%0d t=%b want w=45 p=%0d t=0", width, period, timeout, FRM); end
    en = 1'b1;
    clear_mon();
    run_frames(1'b0, 1'b1);
    model_expect(1'b1);
    vectors++;
    if (mon_w.size() !== exp_w.size()) begin miscompares++; $display("FAIL enable_count: got %0d strobes want %0d", mon_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < mon_w.size(); i++) begin
      vectors++;
      if (mon_w[i] !== exp_w[i] || mon_p[i] !== exp_p[i] || mon_r[i] !== exp_r[i] || mon_t[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL enable_sample%0d: got w=%0d p=%0d r=%b t=%b want w=%0d p=%0d r=%b t=0", i, mon_w[i], mon_p[i], mon_r[i], mon_t[i], exp_w[i], exp_p[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    fr_h.delete(); fr_p.delete();
    for (int i = 0; i < 8; i++) begin
      int h;
      int p;
      h = int'($urandom_range(30, 70));
      if ($urandom_range(0, 5) == 0) p = int'($urandom_range(PMAX + 50, PMAX + 300));
      else p = int'($urandom_range(h + 30, PMAX));
      fr_h.push_back(h);
      fr_p.push_back(p);
    end
    run_frames(1'b0, 1'b1);
    model_expect(1'b1);
    vectors++;
    if (mon_w.size() !== exp_w.size()) begin miscompares++; $display("FAIL random_count: got %0d strobes want %0d", mon_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < mon_w.size(); i++) begin
      vectors++;
      if (mon_w[i] !== exp_w[i] || mon_p[i] !== exp_p[i] || mon_r[i] !== exp_r[i] || mon_t[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL random_sample%0d: got w=%0d p=%0d r=%b t=%b want w=%0d p=%0d r=%b t=0", i, mon_w[i], mon_p[i], mon_r[i], mon_t[i], exp_w[i], exp_p[i], exp_r[i]);
      end
    end
    vectors++; if (to_c.size() !== exp_to) begin miscompares++; $display("FAIL random_timeouts: got %0d want %0d", to_c.size(), exp_to); end
  endtask

  initial begin
    en  = 1'b1;
    rst = 1'b1;
    pwm = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_nominal();
    test_glitch();
    test_timeout();
    test_range();
    test_rst_mid();
    test_boundary();
    test_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
